// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned CODE_W   = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } statetype_t;

  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1110;

  // Indexed by {row, col}; entry 0 is row 0 / col 0.
  localparam logic [15:0][CODE_W-1:0] KEYMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Lowest-index active-low row; only meaningful when some row is low.
  function automatic logic [IDX_W-1:0] low_row_idx(input logic [NUM_ROWS-1:0] r);
    logic [IDX_W-1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column rotation, press/release debounce,
// one keyValid pulse per accepted press. scanTick is an enable, never a clock.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned CNT_W          = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                scanTick,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [CODE_W-1:0]   keyCode,
  output logic                keyValid,
  output logic                keyHeld
);

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               ONE_TICK   = (DEBOUNCE_TICKS == 1);

  statetype_t          state, state_next;
  logic [NUM_ROWS-1:0] row_sync;
  logic                scan_tick_q;
  logic                tick;
  logic [IDX_W-1:0]    col_idx, col_idx_next;
  logic [IDX_W-1:0]    row_idx, row_idx_next;
  logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
  logic [CODE_W-1:0]   key_code_next;
  logic                key_valid_next;
  logic                key_held_next;
  logic                any_low;
  logic                row_low;
  logic [IDX_W-1:0]    det_row;

  sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (rows),
    .q      (row_sync)
  );

  // Rising-edge detect of the divided clock.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) scan_tick_q <= 1'b0;
    else         scan_tick_q <= scanTick;
  end

  assign tick    = scanTick & ~scan_tick_q;
  assign any_low = ~&row_sync;
  assign det_row = low_row_idx(row_sync);
  assign row_low = ~row_sync[row_idx];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= SCAN;
      col_idx  <= '0;
      row_idx  <= '0;
      cnt      <= '0;
      cols     <= COL_IDLE;
      keyCode  <= '0;
      keyValid <= 1'b0;
      keyHeld  <= 1'b0;
    end else begin
      state    <= state_next;
      col_idx  <= col_idx_next;
      row_idx  <= row_idx_next;
      cnt      <= cnt_next;
      cols     <= col_drive(col_idx_next);
      keyCode  <= key_code_next;
      keyValid <= key_valid_next;
      keyHeld  <= key_held_next;
    end
  end

  // Next-state logic; transitions only on tick cycles.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) state_next = ONE_TICK ? HELD : DEBOUNCE;
        end
        DEBOUNCE: begin
          if (!row_low)                  state_next = SCAN;
          else if (cnt_inc == CNT_TARGET) state_next = HELD;
        end
        HELD: begin
          if (!row_low && (cnt_inc == CNT_TARGET)) state_next = SCAN;
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    col_idx_next   = col_idx;
    row_idx_next   = row_idx;
    cnt_next       = cnt;
    key_code_next  = keyCode;
    key_valid_next = 1'b0;
    key_held_next  = keyHeld;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            row_idx_next = det_row;
            if (ONE_TICK) begin
              cnt_next       = '0;
              key_code_next  = KEYMAP[{det_row, col_idx}];
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
            end else begin
              cnt_next = CNT_W'(1);
            end
          end else begin
            col_idx_next = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!row_low) begin
            cnt_next     = '0;
            col_idx_next = col_idx + 2'd1;
          end else if (cnt_inc == CNT_TARGET) begin
            cnt_next       = '0;
            key_code_next  = KEYMAP[{row_idx, col_idx}];
            key_valid_next = 1'b1;
            key_held_next  = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        HELD: begin
          // Any low sample restarts release timing.
          if (row_low) begin
            cnt_next = '0;
          end else if (cnt_inc == CNT_TARGET) begin
            cnt_next      = '0;
            key_held_next = 1'b0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          cnt_next      = '0;
          key_held_next = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, debounces presses and emits one registered key event per debounced press.
- Sits directly downstream of clockDivider. The clockDivider's clkDiv output drives this block's scanTick input and paces column rotation and debounce.
- Everything runs in the single system clock domain. scanTick is used as an enable and is never used as a clock.
- Feeds the display/key-history logic with keyCode and a keyValid strobe.

Parameters:
- DEBOUNCE_TICKS, default 4: consecutive scan ticks a row must be stable (pressed or released) to be accepted. Legal range 1..15.
- CNT_W, default 4: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_TICKS.

Ports:
- clk, input, 1: system clock.
- nreset, input, 1: asynchronous, active-low reset.
- scanTick, input, 1: divided clock from clockDivider, synchronous to clk. A rising edge is one scan tick.
- rows, input, 4: keypad rows, active-low (pulled up), asynchronous.
- cols, output, 4: keypad column drive, one-hot-low.
- keyCode, output, 4: hex value of the last accepted key.
- keyValid, output, 1: one-clk pulse when a new key is accepted.
- keyHeld, output, 1: high while the accepted key remains pressed.

Behaviour:
- Reset values (async assert, sync deassert): cols=4'b1110, keyCode=4'h0, keyValid=0, keyHeld=0, state=SCAN, counter=0, row synchronizer=4'b1111.
- Row inputs: rows pass through a 2-flop synchronizer (rowSync).
- Tick detection: tick = scanTick & ~scanTickQ, where scanTickQ is scanTick delayed by one clk. All FSM and counter updates happen only on tick cycles.
- Usage requirement: the scanTick period must be at least 4 clk cycles, so the synchronizer settles between ticks.
- Column index mapping: col 0 = 1110, col 1 = 1101, col 2 = 1011, col 3 = 0111.
- Keymap, row by row from row 0 to row 3, columns 0 to 3:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E, 0, F, D
- SCAN state:
  - On a tick with rowSync == 1111, cols rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - On a tick with any rowSync bit low: latch the lowest-index low row and the current column, set counter=1, go to DEBOUNCE. cols holds.
  - If DEBOUNCE_TICKS == 1, accept immediately and go straight to HELD.
- DEBOUNCE state: on each tick:
  - If the latched row is still low: counter increments. When counter reaches DEBOUNCE_TICKS, load keyCode from the keymap, pulse keyValid, set keyHeld=1, clear counter, go to HELD.
  - If the latched row is high: clear counter, go to SCAN, and advance cols on that same tick.
- HELD state: cols stays frozen. On each tick:
  - If the latched row is high: counter increments.
  - If the latched row is low: counter clears, so a release bounce restarts release timing.
  - When counter reaches DEBOUNCE_TICKS: keyHeld=0, counter=0, go to SCAN. cols advances on the next tick.
- keyValid timing: registered, high for exactly one clk. It asserts in the clk cycle after the tick on which acceptance occurs. Acceptance happens on the DEBOUNCE_TICKS-th consecutive pressed tick, counting the detection tick as 1.
- No auto-repeat: a held key yields exactly one keyValid.
- keyCode holds its value until the next accepted key.
- Multiple keys:
  - Keys in other columns are invisible while cols is frozen.
  - Other rows in the same column are ignored; only the latched row is tracked.
  - A simultaneous press in one column resolves to the lowest row index.
- Reset mid-operation: nreset low forces reset values immediately, in any state. A pending keyValid is dropped.
- Width rules:
  - The counter saturates and never wraps.
  - Column index and row index are 2-bit; keymap index = {row, col}.

Decomposition:
- keypad_pkg holds:
  - the state enum, typedef statetype_t: SCAN, DEBOUNCE, HELD;
  - the 16-entry keymap constant, indexed by {row, col};
  - the COL_IDLE constant, 4'b1110.
- Sub-module sync2: a parameterised-width 2-flop synchronizer with async active-low reset and reset value all-ones. It is instantiated for rows.
- Tick edge detection stays inline.

Test Plan:
- Tick generation: the bench drives scanTick with a period of 8 clk. The bench models the keypad by pulling a row low whenever that key is "pressed" and its column is driven low.
- Reset and idle scan: release nreset with no key pressed -> cols=1110, keyValid=0, keyCode=0. Successive ticks give 1101, 1011, 0111, 1110.
- Clean press: press '5' (row 1, col 1) for 10 ticks -> exactly one keyValid pulse, on the 4th tick after detection. keyCode=4'h5, keyHeld=1, cols frozen at 1101.
- Press bounce: '9' pressed for 2 ticks, released for 1, pressed for 2 -> no keyValid, and cols resumes rotating after the release tick.
- Release bounce: hold 'A' for 20 ticks, then release with a 1-tick low glitch after 2 high ticks -> a single keyValid with keyCode=4'hA. keyHeld falls only after 4 consecutive high ticks, then scanning resumes.
- Two keys: hold '1', then press '9' while '1' is held -> no pulse for '9'. Release '1' -> after the release debounce, scanning finds '9' and produces one pulse with keyCode=4'h9.
- Reset mid-operation: assert nreset during HELD with '0' pressed -> cols=1110, keyHeld=0, keyCode=0 immediately, without waiting for a clk edge.
